// File: rtl/lbm_pkg.sv
// Shared types for the LBM streaming scheduler: direction and FSM state
// enums, plus the per-direction column/row steps used to form neighbour
// addresses.
package lbm_pkg;

    localparam int NUM_DIRS = 9;

    // Bit position of each direction in the write-enable vector.
    typedef enum logic [3:0] {
        DIR_C0 = 4'd0,
        DIR_N  = 4'd1,
        DIR_NE = 4'd2,
        DIR_E  = 4'd3,
        DIR_SE = 4'd4,
        DIR_S  = 4'd5,
        DIR_SW = 4'd6,
        DIR_W  = 4'd7,
        DIR_NW = 4'd8
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Column step (East positive) and row step (South positive) per direction.
    localparam int DIR_DX [NUM_DIRS] = '{0,  0,  1, 1, 1, 0, -1, -1, -1};
    localparam int DIR_DY [NUM_DIRS] = '{0, -1, -1, 0, 1, 1,  1,  0, -1};

endpackage

// File: rtl/lbm_stream_scheduler_if.sv
// Control and RAM-strobe bundle between the solver, the streaming
// scheduler and the nine direction RAMs.
//
// Handshake: start is a level request, taken only when the scheduler is in
// IDLE with en high; done is a single-cycle strobe in DONE with no ready
// back-pressure; en stalls the whole sequencer and masks every strobe.
interface lbm_stream_scheduler_if
    import lbm_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8
);
    logic                         start;
    logic                         en;
    logic [15:0]                  num_steps;
    logic                         busy;
    logic                         done;
    logic                         rd_en;
    logic [ADDRESS_WIDTH-1:0]     rd_addr;
    logic [NUM_DIRS-1:0]          wr_en;
    logic [NUM_DIRS*ADDRESS_WIDTH-1:0] wr_addr;
    logic                         buf_sel;
    logic [15:0]                  step_count;
    state_e                       state_dbg;

    modport master (
        output start, en, num_steps,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, buf_sel,
               step_count, state_dbg
    );

    modport slave (
        input  start, en, num_steps,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, buf_sel,
               step_count, state_dbg
    );
endinterface

// File: rtl/lbm_neighbor_addr.sv
// Combinational neighbour address generator for one cell. With
// LBM_PERIODIC_EN defined, targets wrap around the grid edges; otherwise
// off-grid targets are flagged invalid and their address forced to 0.
module lbm_neighbor_addr
    import lbm_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int HEIGHT        = 16,
    parameter int ADDRESS_WIDTH = 8,
    parameter int ROW_W         = 4,
    parameter int COL_W         = 4
) (
    input  logic [ROW_W-1:0]                    row,
    input  logic [COL_W-1:0]                    col,
    input  logic [ADDRESS_WIDTH-1:0]            index,
    output logic [NUM_DIRS*ADDRESS_WIDTH-1:0]   addr,
    output logic [NUM_DIRS-1:0]                 valid
);
    localparam int N_CELLS = WIDTH * HEIGHT;

    // Offset the cell index by each direction's step, correcting at edges.
    always_comb begin
        int tr;
        int tc;
        int a;
        addr  = '0;
        valid = '0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            tr = int'(row) + DIR_DY[d];
            tc = int'(col) + DIR_DX[d];
            a  = int'(index) + DIR_DX[d] + DIR_DY[d] * WIDTH;
`ifdef LBM_PERIODIC_EN
            if (tc < 0)       a = a + WIDTH;
            if (tc >= WIDTH)  a = a - WIDTH;
            if (tr < 0)       a = a + N_CELLS;
            if (tr >= HEIGHT) a = a - N_CELLS;
            valid[d] = 1'b1;
`else
            valid[d] = (tr >= 0) && (tr < HEIGHT) && (tc >= 0) && (tc < WIDTH);
            if (!valid[d]) a = 0;
`endif
            addr[d*ADDRESS_WIDTH +: ADDRESS_WIDTH] = ADDRESS_WIDTH'(a);
        end
    end
endmodule

// File: rtl/lbm_stream_scheduler.sv
// LBM streaming-step sequencer: walks the grid in raster order, one READ
// and one nine-way scatter WRITE per cell, for num_steps timesteps with a
// ping-pong bank select. Edge handling follows LBM_PERIODIC_EN (wrap when
// defined, mask when undefined).
module lbm_stream_scheduler
    import lbm_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int HEIGHT        = 16,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    lbm_stream_scheduler_if.slave bus
);
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int COL_W = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] index_q, index_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [15:0]              step_q, step_d;
    logic [15:0]              target_q, target_d;
    logic                     buf_q, buf_d;

    logic                                nb_last_col;
    logic                                nb_last_cell;
    logic [15:0]                         step_inc;
    logic [NUM_DIRS*ADDRESS_WIDTH-1:0]   nb_addr;
    logic [NUM_DIRS-1:0]                 nb_valid;

    assign nb_last_col  = (col_q == COL_W'(WIDTH - 1));
    assign nb_last_cell = nb_last_col && (row_q == ROW_W'(HEIGHT - 1));
    assign step_inc     = step_q + 16'd1;

    lbm_neighbor_addr #(
        .WIDTH         (WIDTH),
        .HEIGHT        (HEIGHT),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .ROW_W         (ROW_W),
        .COL_W         (COL_W)
    ) u_neighbor (
        .row   (row_q),
        .col   (col_q),
        .index (index_q),
        .addr  (nb_addr),
        .valid (nb_valid)
    );

    // Next-state and counter update; everything holds while en is low.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        row_d    = row_q;
        col_d    = col_q;
        step_d   = step_q;
        target_d = target_q;
        buf_d    = buf_q;
        if (bus.en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        target_d = bus.num_steps;
                        index_d  = '0;
                        row_d    = '0;
                        col_d    = '0;
                        step_d   = '0;
                        state_d  = (bus.num_steps == 16'd0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: state_d = ST_WRITE;
                ST_WRITE: begin
                    if (nb_last_cell) begin
                        step_d  = step_inc;
                        buf_d   = ~buf_q;
                        index_d = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = (step_inc == target_q) ? ST_DONE : ST_READ;
                    end else begin
                        index_d = index_q + ADDRESS_WIDTH'(1);
                        if (nb_last_col) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                        state_d = ST_READ;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            index_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            step_q   <= '0;
            target_q <= '0;
            buf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            row_q    <= row_d;
            col_q    <= col_d;
            step_q   <= step_d;
            target_q <= target_d;
            buf_q    <= buf_d;
        end
    end

    // Moore output decode; en gates only the strobes, not the addresses.
    always_comb begin
        bus.busy       = (state_q != ST_IDLE);
        bus.done       = (state_q == ST_DONE) && bus.en;
        bus.rd_en      = (state_q == ST_READ) && bus.en;
        bus.rd_addr    = (state_q == ST_READ) ? index_q : '0;
        bus.wr_en      = ((state_q == ST_WRITE) && bus.en) ? nb_valid : '0;
        bus.wr_addr    = (state_q == ST_WRITE) ? nb_addr : '0;
        bus.buf_sel    = buf_q;
        bus.step_count = step_q;
        bus.state_dbg  = state_q;
    end
endmodule

// File: tb/tb_lbm_stream_scheduler.sv
// Directed bench for lbm_stream_scheduler on a 4x3 grid: reset, cell-level
// address vectors, multi-step runs, zero steps, en stalls, and mid-run
// reset. Periodic-mode vectors are selected by LBM_PERIODIC_EN.
module tb_lbm_stream_scheduler;
    import lbm_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 8;

    typedef struct {
        int          cyc;
        logic        rd_en;
        logic [7:0]  rd_addr;
        logic [8:0]  wr_en;
        logic [71:0] wr_addr;
        logic        busy;
        logic        done;
        logic        buf_sel;
        logic [15:0] step_count;
    } vec_t;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lbm_stream_scheduler_if #(.ADDRESS_WIDTH(AW)) bus ();

    lbm_stream_scheduler #(
        .WIDTH         (W),
        .HEIGHT        (H),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total = 0;
    int         bad   = 0;
    vec_t       vecs [8];
    logic [7:0] exp_q [$];

    // Scoreboard compare
    task automatic chk(input string name, input int cyc, input logic [71:0] act,
                       input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [71:0] pk(input int c0, input int n, input int ne,
                                       input int e, input int se, input int s,
                                       input int sw, input int w, input int nw);
        return {8'(nw), 8'(w), 8'(sw), 8'(s), 8'(se), 8'(e), 8'(ne), 8'(n), 8'(c0)};
    endfunction

    function automatic vec_t mkv(input int cyc, input logic rd_en, input logic [7:0] rd_addr,
                                 input logic [8:0] wr_en, input logic [71:0] wr_addr,
                                 input logic busy, input logic done, input logic buf_sel,
                                 input logic [15:0] step_count);
        vec_t v;
        v.cyc = cyc; v.rd_en = rd_en; v.rd_addr = rd_addr; v.wr_en = wr_en;
        v.wr_addr = wr_addr; v.busy = busy; v.done = done; v.buf_sel = buf_sel;
        v.step_count = step_count;
        return v;
    endfunction

    // Driver tasks; both leave the bench 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] ns);
        bus.num_steps = ns;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    initial begin
        int first_done;
        int done_cnt;

        // Hand-computed vectors for a one-step run
        vecs[0] = mkv(1, 1, 0, 9'h000, 72'h0, 1, 0, 0, 0);
`ifdef LBM_PERIODIC_EN
        vecs[1] = mkv(2, 0, 0, 9'h1FF, pk(0, 8, 9, 1, 5, 4, 7, 3, 11), 1, 0, 0, 0);
        vecs[2] = mkv(8, 0, 0, 9'h1FF, pk(3, 11, 8, 0, 4, 7, 6, 2, 10), 1, 0, 0, 0);
        vecs[5] = mkv(24, 0, 0, 9'h1FF, pk(11, 7, 4, 8, 0, 3, 2, 10, 6), 1, 0, 0, 0);
`else
        vecs[1] = mkv(2, 0, 0, 9'h039, pk(0, 0, 0, 1, 5, 4, 0, 0, 0), 1, 0, 0, 0);
        vecs[2] = mkv(8, 0, 0, 9'h0E1, pk(3, 0, 0, 0, 0, 7, 6, 2, 0), 1, 0, 0, 0);
        vecs[5] = mkv(24, 0, 0, 9'h183, pk(11, 7, 0, 0, 0, 0, 0, 10, 6), 1, 0, 0, 0);
`endif
        vecs[3] = mkv(11, 1, 5, 9'h000, 72'h0, 1, 0, 0, 0);
        vecs[4] = mkv(12, 0, 0, 9'h1FF, pk(5, 1, 2, 6, 10, 9, 8, 4, 0), 1, 0, 0, 0);
        vecs[6] = mkv(25, 0, 0, 9'h000, 72'h0, 1, 1, 1, 1);
        vecs[7] = mkv(26, 0, 0, 9'h000, 72'h0, 0, 0, 1, 1);

        // Reset with start held high
        bus.start = 1'b0;
        bus.en = 1'b1;
        bus.num_steps = 16'd1;
        rst = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", 0, bus.busy, 0);
        chk("rst_done", 0, bus.done, 0);
        chk("rst_rd_en", 0, bus.rd_en, 0);
        chk("rst_rd_addr", 0, bus.rd_addr, 0);
        chk("rst_wr_en", 0, bus.wr_en, 0);
        chk("rst_wr_addr", 0, bus.wr_addr, 0);
        chk("rst_buf_sel", 0, bus.buf_sel, 0);
        chk("rst_step_count", 0, bus.step_count, 0);
        chk("rst_state", 0, bus.state_dbg, ST_IDLE);
        rst = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1 chk("post_rst_busy", 0, bus.busy, 0);

        // One step: table vectors plus per-cycle strobe timing
        do_reset();
        do_start(16'd1);
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            chk("rd_en", c, bus.rd_en, (c % 2 == 1) && (c < 25));
            chk("rd_addr", c, bus.rd_addr, ((c % 2 == 1) && (c < 25)) ? (c - 1) / 2 : 0);
            chk("wr_c0", c, bus.wr_en[0], (c % 2 == 0) && (c <= 24));
            chk("done", c, bus.done, c == 25);
            for (int v = 0; v < 8; v++) begin
                if (vecs[v].cyc == c) begin
                    chk("v_rd_en", c, bus.rd_en, vecs[v].rd_en);
                    chk("v_rd_addr", c, bus.rd_addr, vecs[v].rd_addr);
                    chk("v_wr_en", c, bus.wr_en, vecs[v].wr_en);
                    chk("v_wr_addr", c, bus.wr_addr, vecs[v].wr_addr);
                    chk("v_busy", c, bus.busy, vecs[v].busy);
                    chk("v_done", c, bus.done, vecs[v].done);
                    chk("v_buf_sel", c, bus.buf_sel, vecs[v].buf_sel);
                    chk("v_step_count", c, bus.step_count, vecs[v].step_count);
                end
            end
            @(posedge clk);
            #1;
        end

        // Two steps: read order via expected queue, bank toggling, done timing
        do_reset();
        exp_q.delete();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < W * H; k++) exp_q.push_back(8'(k));
        first_done = -1;
        done_cnt = 0;
        do_start(16'd2);
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            if (bus.rd_en) begin
                if (exp_q.size() == 0) chk("extra_read", c, bus.rd_addr, 72'h1FF);
                else chk("rd_seq", c, bus.rd_addr, exp_q.pop_front());
            end
            if (bus.done) begin
                done_cnt++;
                if (first_done < 0) first_done = c;
            end
            if (c == 1 || c == 25) begin
                chk("s2_rd_en", c, bus.rd_en, 1);
                chk("s2_rd_addr", c, bus.rd_addr, 0);
            end
            if (c == 25) chk("s2_buf_sel", c, bus.buf_sel, 1);
            if (c == 49) begin
                chk("s2_buf_sel", c, bus.buf_sel, 0);
                chk("s2_step_count", c, bus.step_count, 2);
            end
            @(posedge clk);
            #1;
        end
        chk("s2_reads_left", 55, exp_q.size(), 0);
        chk("s2_first_done", 55, first_done, 49);
        chk("s2_done_count", 55, done_cnt, 1);

        // Zero steps: immediate done, no strobes
        do_reset();
        do_start(16'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("z_done", c, bus.done, c == 1);
            chk("z_busy", c, bus.busy, c == 1);
            chk("z_rd_en", c, bus.rd_en, 0);
            chk("z_wr_en", c, bus.wr_en, 0);
            @(posedge clk);
            #1;
        end

        // en low in cycles 10..12, start pulsed while busy
        do_reset();
        do_start(16'd1);
        first_done = -1;
        for (int c = 1; c <= 32; c++) begin
            bus.en = !(c >= 10 && c <= 12);
            bus.start = (c == 5);
            if (c == 5) bus.num_steps = 16'd3;
            @(negedge clk);
            if (bus.done && first_done < 0) first_done = c;
            if (c >= 10 && c <= 12) begin
                chk("en_rd_en", c, bus.rd_en, 0);
                chk("en_wr_en", c, bus.wr_en, 0);
            end
            if (c == 13) begin
                chk("en_resume_wr", c, bus.wr_en[0], 1);
                chk("en_resume_addr", c, bus.wr_addr[7:0], 4);
            end
            if (c == 14) chk("en_resume_rd", c, bus.rd_addr, 5);
            if (c == 28) chk("en_step_count", c, bus.step_count, 1);
            if (c == 29) chk("en_busy_drop", c, bus.busy, 0);
            @(posedge clk);
            #1;
        end
        bus.en = 1'b1;
        chk("en_first_done", 32, first_done, 28);

        // Reset asserted in cycle 15 of a run
        do_reset();
        do_start(16'd1);
        for (int c = 1; c <= 20; c++) begin
            rst = (c == 15);
            @(negedge clk);
            if (c == 15) chk("mr_rd_en_before", c, bus.rd_en, 1);
            if (c == 16) begin
                chk("mr_busy", c, bus.busy, 0);
                chk("mr_step_count", c, bus.step_count, 0);
            end
            if (c >= 16) begin
                chk("mr_rd_en", c, bus.rd_en, 0);
                chk("mr_wr_en", c, bus.wr_en, 0);
                chk("mr_done", c, bus.done, 0);
            end
            @(posedge clk);
            #1;
        end

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lbm_stream_scheduler.md
# lbm_stream_scheduler

Sequences the LBM streaming step over a WIDTH×HEIGHT grid whose nine distribution directions live in nine separate RAMs. Walks cells in raster order using row/column counters (no modulo or divide), issues one read and one nine-way scatter write per cell, and masks or wraps writes at grid edges. Runs a programmed number of timesteps with ping-pong bank selection, and reports completion to the top-level solver.

## Interface
- WIDTH, 16, grid columns (≥2)
- HEIGHT, 16, grid rows (≥2)
- ADDRESS_WIDTH, 8, cell address width, ≥ clog2(WIDTH·HEIGHT)
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  run request; sampled only in IDLE
- en  in  1  advance enable; low freezes the sequencer
- num_steps  in  16  timesteps to run; latched on accepted start
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  one-cycle pulse in DONE
- rd_en  out  1  read strobe, all nine RAMs
- rd_addr  out  ADDRESS_WIDTH  current cell index
- wr_en  out  9  per-direction write enable; bit order: C0=0, N, NE, E, SE, S, SW, W, NW=8
- wr_addr  out  9·ADDRESS_WIDTH  direction d destination at [d·ADDRESS_WIDTH +: ADDRESS_WIDTH]
- buf_sel  out  1  source bank; writes target the other bank
- step_count  out  16  completed timesteps in the current run

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: on start, latch num_steps, clear index/row/col/step_count, and go to READ. If num_steps==0, go to DONE instead.
- READ: rd_en=1, rd_addr=index → WRITE.
- WRITE: assert wr_en mask and wr_addr for the cell; RAM data_out from READ is valid this cycle.
  - Not the last cell: index+1; col+1, or col←0 and row+1 when col==WIDTH-1 → READ.
  - Last cell: step_count+1 and toggle buf_sel; clear index/row/col; go to DONE if the new step_count==num_steps, else READ.
- DONE: done=1 → IDLE.
- Destination address is cell + direction offset. North is row−1; East is col+1.
- Without wrap, a direction whose target leaves the grid has its wr_en bit 0 and its wr_addr slice 0. C0 is always enabled, target = index.
- Outputs are decoded from registered state/counters (Moore). Outside READ, rd_en=0 and rd_addr=0. Outside WRITE, wr_en=0 and wr_addr=0.
- en low: state, counters and buf_sel hold. rd_en/wr_en are forced 0 and done is suppressed until en returns.
- start outside IDLE is ignored.

## Timing
- Reset values: state IDLE; all outputs 0, including buf_sel and step_count.
- rst mid-run returns to IDLE on the next edge with no further strobes.
- Start accepted at edge 0. Cell k of step s: READ at cycle 2·(s·N+k)+1, WRITE one cycle later, where N=WIDTH·HEIGHT.
- done at cycle 2·N·num_steps+1, or cycle 1 if num_steps==0. Each en-low cycle adds one cycle of delay.
- RAM read latency is 1 cycle; write commits on the edge ending WRITE.

## Configuration
- LBM_PERIODIC_EN defined: edges wrap.
  - row −1 → HEIGHT−1; row HEIGHT → 0; col −1 → WIDTH−1; col WIDTH → 0.
  - wr_en is always 9'h1FF in WRITE.
- LBM_PERIODIC_EN undefined: out-of-grid directions are masked as above. Bounce-back is handled downstream.

## Structure
- lbm_pkg: direction enum (C0..NW, values 0..8), state enum, and direction dx/dy constant arrays.
- Sub-module lbm_neighbor_addr: combinational; (row, col, index) → 9 addresses + 9 valid bits. Wrap/mask behaviour is selected by LBM_PERIODIC_EN.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3.
- Reset: rst high 2 cycles → all outputs 0, no strobes. start during rst is ignored.
- Mask mode, num_steps=1, cell 0 WRITE (cycle 2):
  - wr_en=9'h039
  - addresses: C0=0, E=1, SE=5, S=4
- Interior cell 5 WRITE (cycle 12):
  - wr_en=9'h1FF
  - addresses: C0=5, N=1, NE=2, E=6, SE=10, S=9, SW=8, W=4, NW=0
- LBM_PERIODIC_EN, cell 0:
  - wr_en=9'h1FF
  - addresses: N=8, NE=9, W=3, SW=7, NW=11, E=1, SE=5, S=4
- num_steps=2:
  - READ of cell 0 at cycles 1 and 25
  - buf_sel=1 at cycle 25, 0 at cycle 49
  - done only at cycle 49, step_count=2
  - num_steps=0 → done at cycle 1, no rd_en/wr_en
- en low cycles 10–12 → no strobes in those cycles; done moves from 25 to 28. start pulsed while busy → ignored. rst at cycle 15 → IDLE at 16, busy=0.
